// File: rtl/scope_pkg.sv
// Shared widths and capture-FSM state codes for the scope capture writer.
package scope_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FILL  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/scope_capture_writer_if.sv
// Avalon-MM write bus between the capture writer (master) and the RAM's s2 port (slave).
interface scope_capture_writer_if #(
  parameter int ADDR_W = 4
);
  import scope_pkg::*;

  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect;
  logic              avm_write;
  logic [WORD_W-1:0] avm_writedata;
  logic              avm_waitrequest;
  logic              avm_clken;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_clken,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_clken,
    output avm_waitrequest
  );

endinterface

// File: rtl/scope_capture_writer_packer.sv
// 2:1 sample-to-word packer: first sample lands in the low half, the second completes the word.
module scope_sample_packer
  import scope_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                restart,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                word_valid,
  output logic [WORD_W-1:0]   word_data
);

  logic                have_low;
  logic [SAMPLE_W-1:0] low_q;
  logic                half_eff;

  // restart discards any stored half so a same-cycle sample becomes the new low half
  assign half_eff   = have_low & ~restart;
  assign word_valid = in_valid & half_eff;
  assign word_data  = {in_data, low_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      have_low <= 1'b0;
      low_q    <= '0;
    end else if (in_valid) begin
      have_low <= ~half_eff;
      if (!half_eff) low_q <= in_data;
    end else if (restart) begin
      have_low <= 1'b0;
    end
  end

endmodule

// File: rtl/scope_capture_writer.sv
// Avalon-MM write master: packs ADC samples two per word and fills the capture RAM
// from address 0 upward, then reports done.
module scope_capture_writer #(
  parameter int ADDR_W    = 4,
  parameter int SAMPLE_W  = 16,
  parameter int NUM_WORDS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   sample_valid,
  input  logic [SAMPLE_W-1:0]    sample_data,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [ADDR_W:0]        words_written,
  scope_capture_writer_if.master avm
);
  import scope_pkg::WORD_W;
  import scope_pkg::state_t;
  import scope_pkg::ST_IDLE;
  import scope_pkg::ST_FILL;
  import scope_pkg::ST_WRITE;
  import scope_pkg::ST_DONE;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W+1)'(NUM_WORDS - 1);

  state_t            state;
  logic              abort_pending;
  logic [ADDR_W:0]   word_count;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q;
  logic              write_q;
  logic              overflow_q;

  logic              start_ok;
  logic              accepted;
  logic              aborting;
  logic              sample_en;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;

  assign start_ok  = start & ~abort & ((state == ST_IDLE) | (state == ST_DONE));
  assign accepted  = write_q & ~avm.avm_waitrequest;
  assign aborting  = abort | abort_pending;
  assign sample_en = sample_valid & ~aborting & ((state == ST_FILL) | (state == ST_WRITE));

  // One packer serves both roles: in FILL it builds the active word, in WRITE the holding word.
  scope_sample_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .restart    (start_ok),
    .in_valid   (sample_en),
    .in_data    (sample_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      abort_pending <= 1'b0;
      word_count    <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      write_q       <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (start) begin
            state      <= ST_FILL;
            word_count <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
          end
        end
        ST_FILL: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (word_valid) begin
            data_q  <= word_data;
            write_q <= 1'b1;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // a stalled write must complete before an abort can take effect
          if (abort) abort_pending <= 1'b1;
          if (accepted) begin
            word_count <= word_count + 1'b1;
            if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
            if (aborting || (word_count == LAST_COUNT)) begin
              write_q       <= 1'b0;
              abort_pending <= 1'b0;
              state         <= aborting ? ST_IDLE : ST_DONE;
            end else if (word_valid) begin
              data_q <= word_data;
            end else begin
              write_q <= 1'b0;
              state   <= ST_FILL;
            end
          end else if (word_valid) begin
            overflow_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy          = (state == ST_FILL) | (state == ST_WRITE);
  assign done          = (state == ST_DONE);
  assign overflow      = overflow_q;
  assign words_written = word_count;

  assign avm.avm_address    = addr_q;
  assign avm.avm_writedata  = data_q;
  assign avm.avm_write      = write_q;
  assign avm.avm_chipselect = write_q;
  assign avm.avm_byteenable = write_q ? 4'hF : 4'h0;
  assign avm.avm_clken      = 1'b1;

endmodule

// File: tb/tb_scope_capture_writer.sv
// Directed testbench for scope_capture_writer: table-driven full capture plus stall/abort/reset sequences.
module tb_scope_capture_writer;

  localparam int ADDR_W    = 4;
  localparam int NUM_WORDS = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [4:0]  words_written;

  scope_capture_writer_if #(.ADDR_W(ADDR_W)) avm_bus ();

  scope_capture_writer #(
    .ADDR_W    (ADDR_W),
    .SAMPLE_W  (16),
    .NUM_WORDS (NUM_WORDS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .words_written (words_written),
    .avm           (avm_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        ab;
    logic        sv;
    logic [15:0] sd;
    logic        wr;
    logic        e_busy;
    logic        e_done;
    logic        e_write;
    logic [3:0]  e_addr;
    logic [4:0]  e_ww;
    logic        chk;
    logic [31:0] e_data;
  } vec_t;

  vec_t        vecs [34];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          stall_left;
  logic        wr_now;
  logic [3:0]  acc_addr [$];
  logic [31:0] acc_data [$];

  function automatic vec_t mkVec(input logic st, ab, sv, input logic [15:0] sd, input logic wr,
                                 input logic eb, ed, ew, input logic [3:0] ea, input logic [4:0] eww,
                                 input logic chk, input logic [31:0] edata);
    vec_t v;
    v.st = st; v.ab = ab; v.sv = sv; v.sd = sd; v.wr = wr;
    v.e_busy = eb; v.e_done = ed; v.e_write = ew; v.e_addr = ea; v.e_ww = eww;
    v.chk = chk; v.e_data = edata;
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge, log any write accepted at the next rising edge.
  task automatic applyStimulus(input logic st, ab, sv, input logic [15:0] sd, input logic wr);
    @(negedge clk);
    start        = st;
    abort        = ab;
    sample_valid = sv;
    sample_data  = sd;
    avm_bus.avm_waitrequest = wr;
    #1;
    if (avm_bus.avm_write && !wr && !reset) begin
      acc_addr.push_back(avm_bus.avm_address);
      acc_data.push_back(avm_bus.avm_writedata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic e_busy, e_done, e_write, e_ovf,
                             input logic [3:0] e_addr, input logic [4:0] e_ww,
                             input logic chk_data, input logic [31:0] e_data);
    logic ok;
    ok = (busy === e_busy) && (done === e_done) && (overflow === e_ovf) &&
         (words_written === e_ww) && (avm_bus.avm_write === e_write) &&
         (avm_bus.avm_chipselect === e_write) &&
         (avm_bus.avm_byteenable === (e_write ? 4'hF : 4'h0)) &&
         (avm_bus.avm_clken === 1'b1) && (avm_bus.avm_address === e_addr) &&
         (!chk_data || (avm_bus.avm_writedata === e_data));
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("[TB] FAIL %s: got busy=%b done=%b ovf=%b ww=%0d wr=%b cs=%b be=%h ck=%b addr=%0d data=%h ; want busy=%b done=%b ovf=%b ww=%0d wr=%b addr=%0d data=%h(chk=%b)",
               name, busy, done, overflow, words_written, avm_bus.avm_write, avm_bus.avm_chipselect,
               avm_bus.avm_byteenable, avm_bus.avm_clken, avm_bus.avm_address, avm_bus.avm_writedata,
               e_busy, e_done, e_ovf, e_ww, e_write, e_addr, e_data, chk_data);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Compare the logged writes against the expected {addr, data} list of a full capture.
  task automatic checkWrites(input string name, input int skip_from);
    logic [31:0] exp;
    checkValue({name, "_count"}, 32'(acc_addr.size()), 32'(NUM_WORDS));
    for (int j = 0; j < NUM_WORDS; j++) begin
      if (j < acc_addr.size()) begin
        if (j < skip_from) exp = {16'(2*j+2), 16'(2*j+1)};
        else               exp = {16'(2*j+4), 16'(2*j+3)};
        checkValue($sformatf("%s_addr%0d", name, j), 32'(acc_addr[j]), 32'(j));
        checkValue($sformatf("%s_data%0d", name, j), acc_data[j], exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; sample_valid = 1'b0; sample_data = '0;
    avm_bus.avm_waitrequest = 1'b0;

    // test 1 table: start, 32 samples back to back, then one settle cycle
    vecs[0] = mkVec(1, 0, 0, 16'd0, 0, 1, 0, 0, 4'd0, 5'd0, 0, 32'h0);
    for (int k = 1; k <= 32; k++) begin
      if (k % 2 == 0)
        vecs[k] = mkVec(0, 0, 1, 16'(k), 0, 1, 0, 1, 4'(k/2-1), 5'(k/2-1), 1, {16'(k), 16'(k-1)});
      else
        vecs[k] = mkVec(0, 0, 1, 16'(k), 0, 1, 0, 0, 4'((k-1)/2), 5'((k-1)/2), 0, 32'h0);
    end
    vecs[33] = mkVec(0, 0, 0, 16'd0, 0, 0, 1, 0, 4'd15, 5'd16, 0, 32'h0);

    applyStimulus(0, 0, 0, 16'd0, 0);
    applyStimulus(0, 0, 1, 16'd9, 0);
    checkOutput("reset_state", 0, 0, 0, 0, 4'd0, 5'd0, 1, 32'h0);
    reset = 1'b0;

    $display("[TB] test 1: full capture, no stalls");
    acc_addr.delete(); acc_data.delete();
    for (int i = 0; i < 34; i++) begin
      applyStimulus(vecs[i].st, vecs[i].ab, vecs[i].sv, vecs[i].sd, vecs[i].wr);
      checkOutput($sformatf("t1_v%0d", i), vecs[i].e_busy, vecs[i].e_done, vecs[i].e_write, 1'b0,
                  vecs[i].e_addr, vecs[i].e_ww, vecs[i].chk, vecs[i].e_data);
    end
    checkWrites("t1", NUM_WORDS);

    $display("[TB] test 2: 3-cycle stall on word 2 drops holding word");
    applyStimulus(1, 0, 0, 16'd0, 0);
    checkOutput("t2_start_from_done", 1, 0, 0, 0, 4'd0, 5'd0, 0, 32'h0);
    acc_addr.delete(); acc_data.delete();
    for (int c = 1; c <= 35; c++) begin
      applyStimulus(0, 0, c <= 34, 16'(c), (c >= 7) && (c <= 9));
      if (c == 6) checkOutput("t2_word2_issue", 1, 0, 1, 0, 4'd2, 5'd2, 1, 32'h00060005);
      if (c == 7) checkOutput("t2_stall1", 1, 0, 1, 0, 4'd2, 5'd2, 1, 32'h00060005);
      if (c == 8) checkOutput("t2_stall2_drop", 1, 0, 1, 1, 4'd2, 5'd2, 1, 32'h00060005);
      if (c == 9) checkOutput("t2_stall3", 1, 0, 1, 1, 4'd2, 5'd2, 1, 32'h00060005);
      if (c == 10) checkOutput("t2_back_to_back", 1, 0, 1, 1, 4'd3, 5'd3, 1, 32'h000A0009);
      if (c == 35) checkOutput("t2_done", 0, 1, 0, 1, 4'd15, 5'd16, 0, 32'h0);
    end
    checkWrites("t2", 3);

    $display("[TB] test 3: sparse samples, random short stalls");
    applyStimulus(1, 0, 0, 16'd0, 0);
    checkOutput("t3_start_clears_ovf", 1, 0, 0, 0, 4'd0, 5'd0, 0, 32'h0);
    acc_addr.delete(); acc_data.delete();
    stall_left = $urandom_range(0, 2);
    for (int c = 1; c <= 4*32 + 12; c++) begin
      if (avm_bus.avm_write && stall_left > 0) begin
        wr_now = 1'b1;
        stall_left--;
      end else begin
        wr_now = 1'b0;
        if (avm_bus.avm_write) stall_left = $urandom_range(0, 2);
      end
      applyStimulus(0, 0, (c % 4 == 0) && (c <= 128), 16'(c/4), wr_now);
      if (done) break;
    end
    checkOutput("t3_done", 0, 1, 0, 0, 4'd15, 5'd16, 0, 32'h0);
    checkWrites("t3", NUM_WORDS);

    $display("[TB] test 4: abort after 5 samples");
    applyStimulus(1, 0, 0, 16'd0, 0);
    acc_addr.delete(); acc_data.delete();
    for (int c = 1; c <= 5; c++) applyStimulus(0, 0, 1, 16'(c), 0);
    checkOutput("t4_before_abort", 1, 0, 0, 0, 4'd2, 5'd2, 0, 32'h0);
    applyStimulus(0, 1, 0, 16'd0, 0);
    checkOutput("t4_after_abort", 0, 0, 0, 0, 4'd2, 5'd2, 0, 32'h0);
    applyStimulus(0, 0, 1, 16'd6, 0);
    checkOutput("t4_idle_ignores_samples", 0, 0, 0, 0, 4'd2, 5'd2, 0, 32'h0);
    checkValue("t4_accepts", 32'(acc_addr.size()), 32'd2);

    $display("[TB] test 5: abort during a 4-cycle stall");
    applyStimulus(1, 0, 0, 16'd0, 0);
    applyStimulus(0, 0, 1, 16'd1, 0);
    applyStimulus(0, 0, 1, 16'd2, 0);
    checkOutput("t5_issue", 1, 0, 1, 0, 4'd0, 5'd0, 1, 32'h00020001);
    applyStimulus(1, 1, 1, 16'd3, 1);
    checkOutput("t5_abort_held", 1, 0, 1, 0, 4'd0, 5'd0, 1, 32'h00020001);
    for (int c = 4; c <= 6; c++) applyStimulus(0, 0, 1, 16'(c), 1);
    checkOutput("t5_still_held", 1, 0, 1, 0, 4'd0, 5'd0, 1, 32'h00020001);
    applyStimulus(0, 0, 1, 16'd7, 0);
    checkOutput("t5_accepted_idle", 0, 0, 0, 0, 4'd1, 5'd1, 0, 32'h0);
    applyStimulus(1, 1, 0, 16'd0, 0);
    checkOutput("t5_abort_beats_start", 0, 0, 0, 0, 4'd1, 5'd1, 0, 32'h0);

    $display("[TB] test 6: reset mid-write");
    applyStimulus(1, 0, 0, 16'd0, 0);
    for (int c = 1; c <= 4; c++) applyStimulus(0, 0, 1, 16'(c), 0);
    applyStimulus(0, 0, 1, 16'd5, 1);
    checkOutput("t6_stalled", 1, 0, 1, 0, 4'd1, 5'd1, 1, 32'h00040003);
    reset = 1'b1;
    applyStimulus(0, 0, 1, 16'd6, 1);
    checkOutput("t6_reset_values", 0, 0, 0, 0, 4'd0, 5'd0, 1, 32'h0);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 16'd0, 0);
    applyStimulus(0, 0, 1, 16'h0011, 0);
    applyStimulus(0, 0, 1, 16'h0022, 0);
    checkOutput("t6_restart_addr0", 1, 0, 1, 0, 4'd0, 5'd0, 1, 32'h00220011);
    applyStimulus(0, 0, 0, 16'd0, 0);
    checkOutput("t6_restart_accept", 1, 0, 0, 0, 4'd1, 5'd1, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
